// File: rtl/pipe_core_param.sv
// pipe_core_param: 4-stage (F/D/E/W) accumulator-style core with forwarding,
// a stalling data-memory handshake, halt on STOP and cycle/retire counters.
module pipe_core_param #(
    parameter int DW = 8,
    parameter int AW = 8,
    parameter int CW = 16
) (
    input  logic          clock,
    input  logic          reset,
    output logic [AW-1:0] imem_addr,
    input  logic [7:0]    imem_rdata,
    output logic          dmem_req,
    output logic          dmem_we,
    output logic [AW-1:0] dmem_addr,
    output logic [DW-1:0] dmem_wdata,
    input  logic          dmem_ack,
    input  logic [DW-1:0] dmem_rdata,
    input  logic [1:0]    dbg_sel,
    output logic [DW-1:0] dbg_data,
    output logic          halted,
    output logic [CW-1:0] cycle_count,
    output logic [CW-1:0] retired_count
);
    logic [DW-1:0] rf [4];
    logic [AW-1:0] pc, d_pc, e_pc;
    logic [7:0]    d_ir, e_ir;
    logic          d_valid, e_valid, w_valid, w_we;
    logic [1:0]    e_ra, e_rb, w_rd;
    logic [DW-1:0] e_a, e_b, w_res;
    logic          flag_n, flag_z;

    logic [1:0]    d_ra, d_rb;
    logic [DW-1:0] rd_a, rd_b, a, b, alu;
    logic [3:0]    op;
    logic          is_ori, is_load, is_store, is_add, is_sub, is_nand, is_stop;
    logic          sets_flags, writes, taken, stop, stall;
    logic [AW-1:0] target;

    // ORI implicitly reads and writes k1, so its source is steered here
    always_comb begin
        d_ra = (d_ir[2:0] == 3'b111) ? 2'd1 : d_ir[7:6];
        d_rb = d_ir[5:4];
        rd_a = (w_valid && w_we && w_rd == d_ra) ? w_res : rf[d_ra];
        rd_b = (w_valid && w_we && w_rd == d_rb) ? w_res : rf[d_rb];
    end

    always_comb begin
        op         = e_ir[3:0];
        is_ori     = op[2:0] == 3'b111;
        is_load    = op == 4'b0000;
        is_store   = op == 4'b0010;
        is_add     = op == 4'b0100;
        is_sub     = op == 4'b0110;
        is_nand    = op == 4'b1000;
        is_stop    = op == 4'b0001;
        sets_flags = is_add || is_sub || is_nand || is_ori;
        writes     = sets_flags || is_load;
        a          = (w_valid && w_we && w_rd == e_ra) ? w_res : e_a;
        b          = (w_valid && w_we && w_rd == e_rb) ? w_res : e_b;
        alu        = is_add ? a + b : is_sub ? a - b : is_nand ? ~(a & b) : a | DW'(e_ir[7:3]);
        taken      = e_valid && ((op == 4'b0101 && flag_z) || (op == 4'b1001 && !flag_z) ||
                                 (op == 4'b1101 && !flag_n));
        target     = e_pc + AW'(1) + AW'(signed'(e_ir[7:4]));
        stop       = e_valid && is_stop;
        dmem_req   = e_valid && (is_load || is_store);
        stall      = dmem_req && !dmem_ack;
    end

    assign imem_addr  = pc;
    assign dmem_we    = is_store;
    assign dmem_addr  = b[AW-1:0];
    assign dmem_wdata = a;
    assign dbg_data   = rf[dbg_sel];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rf            <= '{default: '0};
            pc            <= '0;
            d_pc          <= '0;
            e_pc          <= '0;
            d_ir          <= '0;
            e_ir          <= '0;
            d_valid       <= 1'b0;
            e_valid       <= 1'b0;
            w_valid       <= 1'b0;
            w_we          <= 1'b0;
            e_ra          <= '0;
            e_rb          <= '0;
            w_rd          <= '0;
            e_a           <= '0;
            e_b           <= '0;
            w_res         <= '0;
            flag_n        <= 1'b0;
            flag_z        <= 1'b0;
            halted        <= 1'b0;
            cycle_count   <= '0;
            retired_count <= '0;
        end else if (!halted) begin
            cycle_count <= cycle_count + CW'(1);
            if (w_valid)
                retired_count <= retired_count + CW'(1);
            if (w_valid && w_we)
                rf[w_rd] <= w_res;
            if (e_valid && sets_flags) begin
                flag_n <= alu[DW-1];
                flag_z <= alu == '0;
            end
            w_valid <= e_valid && !stall && !is_stop;
            w_we    <= writes;
            w_rd    <= e_ra;
            w_res   <= is_load ? dmem_rdata : alu;
            if (stop) begin
                halted  <= 1'b1;
                d_valid <= 1'b0;
                e_valid <= 1'b0;
            end else if (stall) begin
                // keep held operands current while the W-stage writer drains
                e_a <= a;
                e_b <= b;
            end else begin
                pc      <= taken ? target : pc + AW'(1);
                d_valid <= !taken;
                d_ir    <= imem_rdata;
                d_pc    <= pc;
                e_valid <= d_valid && !taken;
                e_ir    <= d_ir;
                e_pc    <= d_pc;
                e_ra    <= d_ra;
                e_rb    <= d_rb;
                e_a     <= rd_a;
                e_b     <= rd_b;
            end
        end
    end
endmodule

// File: tb/tb_pipe_core_param.sv
// tb_pipe_core_param: directed programs against pipe_core_param with a ROM,
// a wait-state data RAM model and hand-computed register/counter results.
module tb_pipe_core_param;
    localparam int DW = 8;
    localparam int AW = 8;
    localparam int CW = 16;

    localparam logic [3:0] OP_LD = 4'h0, OP_ST = 4'h2, OP_ADD = 4'h4, OP_SUB = 4'h6,
                           OP_NAND = 4'h8, OP_BZ = 4'h5, OP_BNZ = 4'h9, OP_BPZ = 4'hD;
    localparam logic [7:0] STOP = 8'h01, NOP = 8'h0A;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic [AW-1:0] imem_addr;
    logic [7:0]    imem_rdata;
    logic          dmem_req, dmem_we, dmem_ack;
    logic [AW-1:0] dmem_addr;
    logic [DW-1:0] dmem_wdata, dmem_rdata;
    logic [1:0]    dbg_sel = 2'd0;
    logic [DW-1:0] dbg_data;
    logic          halted;
    logic [CW-1:0] cycle_count, retired_count;

    logic [7:0]    rom [256];
    logic [DW-1:0] mem [256];
    int            ack_wait = 0;
    int            wcnt;
    logic [AW-1:0] mon_addr = '0;
    int            req_cycles, addr_bad, st_cnt;
    logic [AW-1:0] st_addr;
    logic [DW-1:0] st_data;
    int            checks = 0;
    int            errors = 0;

    pipe_core_param #(.DW(DW), .AW(AW), .CW(CW)) dut (
        .clock(clock), .reset(reset),
        .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
        .dbg_sel(dbg_sel), .dbg_data(dbg_data), .halted(halted),
        .cycle_count(cycle_count), .retired_count(retired_count)
    );

    always #5 clock = ~clock;

    assign imem_rdata = rom[imem_addr];
    assign dmem_rdata = mem[dmem_addr];
    assign dmem_ack   = dmem_req && (wcnt >= ack_wait);

    always @(posedge clock)
        wcnt <= (reset || !dmem_req || dmem_ack) ? 0 : wcnt + 1;

    always @(negedge clock) begin
        if (reset) begin
            req_cycles <= 0;
            addr_bad   <= 0;
            st_cnt     <= 0;
            st_addr    <= '0;
            st_data    <= '0;
        end else if (dmem_req) begin
            req_cycles <= req_cycles + 1;
            if (dmem_addr != mon_addr)
                addr_bad <= addr_bad + 1;
            if (dmem_ack && dmem_we) begin
                st_cnt  <= st_cnt + 1;
                st_addr <= dmem_addr;
                st_data <= dmem_wdata;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic check_reg(input string tag, input logic [1:0] sel, input logic [DW-1:0] exp);
        dbg_sel = sel;
        #1;
        check(tag, 32'(dbg_data), 32'(exp));
    endtask

    function automatic logic [7:0] ins(input logic [1:0] ra, input logic [1:0] rb, input logic [3:0] op);
        return {ra, rb, op};
    endfunction

    function automatic logic [7:0] ori(input logic [4:0] imm);
        return {imm, 3'b111};
    endfunction

    function automatic logic [7:0] br(input logic [3:0] imm, input logic [3:0] op);
        return {imm, op};
    endfunction

    task automatic clear();
        for (int i = 0; i < 256; i++) begin
            rom[i] = NOP;
            mem[i] = '0;
        end
        ack_wait = 0;
        mon_addr = '0;
    endtask

    task automatic boot();
        reset = 1'b1;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic wait_halt(input string tag);
        int n = 0;
        while (!halted && n < 400) begin
            @(negedge clock);
            n++;
        end
        check(tag, 32'(halted), 32'd1);
    endtask

    initial begin
        clear();
        #1;
        check("rst_req", 32'(dmem_req), 32'd0);
        check("rst_pc", 32'(imem_addr), 32'd0);
        check("rst_halt", 32'(halted), 32'd0);
        check("rst_cyc", 32'(cycle_count), 32'd0);
        check("rst_ret", 32'(retired_count), 32'd0);
        check_reg("rst_k0", 2'd0, 8'h00);

        // forwarding chain: k2=1, k1=mem[1]=5, k0=mem[5]=3, then 3+5, 8+8
        clear();
        rom[0] = ins(2, 0, OP_LD);
        rom[1] = ins(1, 2, OP_LD);
        rom[2] = ins(0, 1, OP_LD);
        rom[3] = ins(0, 1, OP_ADD);
        rom[4] = ins(0, 0, OP_ADD);
        rom[5] = STOP;
        mem[0] = 8'd1;
        mem[1] = 8'd5;
        mem[5] = 8'd3;
        boot();
        repeat (5) @(negedge clock);
        check("fwd_ret_mid", 32'(retired_count), 32'd2);
        wait_halt("fwd_halt");
        check("fwd_cyc", 32'(cycle_count), 32'd8);
        check("fwd_ret", 32'(retired_count), 32'd5);
        check_reg("fwd_k0", 2'd0, 8'h10);
        check_reg("fwd_k1", 2'd1, 8'h05);
        check_reg("fwd_k2", 2'd2, 8'h01);

        // load with 3 wait cycles, then SUB to zero and taken BZ over an ORI
        clear();
        rom[0] = ori(5'd6);
        rom[1] = ins(2, 1, OP_LD);
        rom[2] = ins(2, 2, OP_SUB);
        rom[3] = br(4'd1, OP_BZ);
        rom[4] = ori(5'd1);
        rom[5] = STOP;
        mem[6] = 8'hA5;
        ack_wait = 3;
        mon_addr = 8'd6;
        boot();
        repeat (8) @(negedge clock);
        check_reg("ld_k2_mid", 2'd2, 8'hA5);
        wait_halt("ld_halt");
        check("ld_req_cycles", 32'(req_cycles), 32'd4);
        check("ld_addr_stable", 32'(addr_bad), 32'd0);
        check("ld_cyc", 32'(cycle_count), 32'd12);
        check("ld_ret", 32'(retired_count), 32'd4);
        check_reg("ld_k1", 2'd1, 8'h06);
        check_reg("ld_k2", 2'd2, 8'h00);

        // untaken BPZ after 0x80, untaken BZ, untaken BNZ on Z=1
        clear();
        rom[0] = ins(0, 3, OP_LD);
        rom[1] = ins(0, 3, OP_ADD);
        rom[2] = br(4'd3, OP_BPZ);
        rom[3] = br(4'd3, OP_BZ);
        rom[4] = ori(5'd2);
        rom[5] = ins(2, 2, OP_SUB);
        rom[6] = br(4'd5, OP_BNZ);
        rom[7] = STOP;
        mem[0] = 8'h80;
        boot();
        wait_halt("nt_halt");
        check("nt_cyc", 32'(cycle_count), 32'd10);
        check("nt_ret", 32'(retired_count), 32'd7);
        check_reg("nt_k0", 2'd0, 8'h80);
        check_reg("nt_k1", 2'd1, 8'h02);

        // backward branch from 1 wraps to 0xFF, forward branch wraps to 4, ORI flags
        clear();
        rom[0]     = ins(0, 0, OP_SUB);
        rom[1]     = br(4'hD, OP_BZ);
        rom[2]     = ori(5'd1);
        rom[3]     = ori(5'd2);
        rom[8'hFF] = br(4'd4, OP_BZ);
        rom[4]     = ori(5'h10);
        rom[5]     = ori(5'h0F);
        rom[6]     = br(4'd1, OP_BZ);
        rom[7]     = br(4'd1, OP_BPZ);
        rom[8]     = ins(1, 1, OP_NAND);
        rom[9]     = STOP;
        boot();
        wait_halt("wrap_halt");
        check("wrap_cyc", 32'(cycle_count), 32'd16);
        check("wrap_ret", 32'(retired_count), 32'd7);
        check_reg("wrap_k1", 2'd1, 8'h1F);
        check_reg("wrap_k0", 2'd0, 8'h00);

        // STOP: first ADD retires, second does not; everything freezes
        clear();
        rom[0] = ori(5'd3);
        rom[1] = ins(1, 1, OP_ADD);
        rom[2] = STOP;
        rom[3] = ins(1, 1, OP_ADD);
        boot();
        wait_halt("stop_halt");
        check("stop_cyc", 32'(cycle_count), 32'd5);
        check("stop_ret", 32'(retired_count), 32'd2);
        check("stop_pc", 32'(imem_addr), 32'd4);
        check_reg("stop_k1", 2'd1, 8'h06);
        repeat (20) @(negedge clock);
        check("stop_cyc_frozen", 32'(cycle_count), 32'd5);
        check("stop_pc_frozen", 32'(imem_addr), 32'd4);
        check("stop_still_halted", 32'(halted), 32'd1);
        check("stop_ret_frozen", 32'(retired_count), 32'd2);

        // reset while a store waits for ack, then rerun with immediate ack
        clear();
        rom[0] = ori(5'd9);
        rom[1] = ins(1, 1, OP_ST);
        rom[2] = ins(2, 1, OP_LD);
        rom[3] = STOP;
        mem[9] = 8'h3C;
        ack_wait = 100;
        mon_addr = 8'd9;
        boot();
        begin
            int n = 0;
            while (!dmem_req && n < 50) begin
                @(negedge clock);
                n++;
            end
            check("mid_req_seen", 32'(dmem_req), 32'd1);
        end
        repeat (2) @(negedge clock);
        #2 reset = 1'b1;
        #1;
        check("mid_req_drop", 32'(dmem_req), 32'd0);
        check("mid_pc", 32'(imem_addr), 32'd0);
        check("mid_cyc", 32'(cycle_count), 32'd0);
        check("mid_ret", 32'(retired_count), 32'd0);
        check("mid_halt", 32'(halted), 32'd0);
        check("mid_no_store", 32'(st_cnt), 32'd0);
        check_reg("mid_k1", 2'd1, 8'h00);
        ack_wait = 0;
        boot();
        wait_halt("rerun_halt");
        check("rerun_cyc", 32'(cycle_count), 32'd6);
        check("rerun_ret", 32'(retired_count), 32'd3);
        check("rerun_st_cnt", 32'(st_cnt), 32'd1);
        check("rerun_st_addr", 32'(st_addr), 32'd9);
        check("rerun_st_data", 32'(st_data), 32'd9);
        check_reg("rerun_k2", 2'd2, 8'h3C);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
